// File: rtl/aes_host_if.sv
// Host-side wrapper for a serial 32-bit AES core. It accepts one 128-bit block
// per valid/ready handshake and streams it to the core as a start pulse plus
// four words. It then waits out the core's fixed latency and collects the four
// result words. The result is held until the host consumes it.
module aes_host_if #(
  parameter int START_CYC = 3,
  parameter int WAIT_CYC  = 62
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [127:0] blk_text,
  input  logic [127:0] blk_key,
  input  logic         blk_encdec,
  output logic         core_start,
  output logic [31:0]  core_data_in,
  output logic [127:0] core_key_in,
  output logic         core_selEncDec,
  input  logic [31:0]  core_data_out,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_text
);

  localparam int MAX_SW  = (START_CYC > WAIT_CYC) ? START_CYC : WAIT_CYC;
  localparam int MAX_CNT = (MAX_SW > 4) ? MAX_SW : 4;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] START_LAST = CW'(START_CYC - 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(WAIT_CYC - 1);
  localparam logic [CW-1:0] WORD_LAST  = CW'(3);

  typedef enum logic [2:0] {
    IDLE,
    START,
    LOAD,
    WAIT,
    UNLOAD,
    HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;

  // Capture strobe and destination word for result collection.
  logic          cap_en;
  logic [1:0]    cap_idx;

  // Registered datapath and outputs.
  logic [127:0]  text_q;
  logic [127:0]  key_q;
  logic          mode_q;
  logic [127:0]  res_q;
  logic          blk_ready_q, blk_ready_d;
  logic          start_q, start_d;
  logic [31:0]   din_q, din_d;
  logic          res_valid_q, res_valid_d;

  // State register and phase counter.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic, counter control, and next values for registered outputs.
  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    accept      = 1'b0;
    cap_en      = 1'b0;
    cap_idx     = 2'd0;
    din_d       = 32'h0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (blk_valid && blk_ready_q) begin
          accept  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == START_LAST) state_d = LOAD;
      end
      LOAD: begin
        if (cnt_q == WORD_LAST) state_d = WAIT;
      end
      WAIT: begin
        // The core registers word 3 on the first WAIT edge. Word 0 of the
        // result is ready WAIT_CYC edges later, which is the edge leaving WAIT.
        if (cnt_q == WAIT_LAST) begin
          state_d = UNLOAD;
          cap_en  = 1'b1;
          cap_idx = 2'd0;
        end
      end
      UNLOAD: begin
        // Words 1..3 arrive on the following three edges. The fourth UNLOAD
        // cycle only lets the last capture settle before HOLD.
        if (cnt_q != WORD_LAST) begin
          cap_en  = 1'b1;
          cap_idx = cnt_q[1:0] + 2'd1;
        end else begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        cnt_d = '0;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;

    if (state_d == LOAD) begin
      unique case (cnt_d[1:0])
        2'd0:    din_d = text_q[127:96];
        2'd1:    din_d = text_q[95:64];
        2'd2:    din_d = text_q[63:32];
        default: din_d = text_q[31:0];
      endcase
    end

    blk_ready_d = (state_d == IDLE);
    start_d     = (state_d == START);
    res_valid_d = (state_d == HOLD);
  end

  // Block latches, result capture, and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      text_q      <= '0;
      key_q       <= '0;
      mode_q      <= 1'b0;
      res_q       <= '0;
      blk_ready_q <= 1'b0;
      start_q     <= 1'b0;
      din_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      blk_ready_q <= blk_ready_d;
      start_q     <= start_d;
      din_q       <= din_d;
      res_valid_q <= res_valid_d;
      if (accept) begin
        text_q <= blk_text;
        key_q  <= blk_key;
        mode_q <= blk_encdec;
      end
      if (cap_en) begin
        unique case (cap_idx)
          2'd0:    res_q[127:96] <= core_data_out;
          2'd1:    res_q[95:64]  <= core_data_out;
          2'd2:    res_q[63:32]  <= core_data_out;
          default: res_q[31:0]   <= core_data_out;
        endcase
      end
    end
  end

  assign blk_ready      = blk_ready_q;
  assign core_start     = start_q;
  assign core_data_in   = din_q;
  assign core_key_in    = key_q;
  assign core_selEncDec = mode_q;
  assign res_valid      = res_valid_q;
  assign res_text       = res_q;

endmodule

// File: tb/tb_aes_host_if.sv
// Self-checking bench for aes_host_if. A stand-in core drives a fresh random
// word every cycle. The reference model is a timeline relative to the accept
// edge: start for cycles 0..2, words on 3..6, capture of the core stream seen
// at edges 69..72, and result valid from cycle 73 until it is consumed.
module tb_aes_host_if;

  localparam int LAT = 73;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         reset;
  logic         blk_valid;
  logic         blk_ready;
  logic [127:0] blk_text;
  logic [127:0] blk_key;
  logic         blk_encdec;
  logic         core_start;
  logic [31:0]  core_data_in;
  logic [127:0] core_key_in;
  logic         core_selEncDec;
  logic [31:0]  core_data_out;
  logic         res_valid;
  logic         res_ready;
  logic [127:0] res_text;

  int n_chk = 0;
  int n_err = 0;

  aes_host_if dut (
    .clk            (clk),
    .reset          (reset),
    .blk_valid      (blk_valid),
    .blk_ready      (blk_ready),
    .blk_text       (blk_text),
    .blk_key        (blk_key),
    .blk_encdec     (blk_encdec),
    .core_start     (core_start),
    .core_data_in   (core_data_in),
    .core_key_in    (core_key_in),
    .core_selEncDec (core_selEncDec),
    .core_data_out  (core_data_out),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_text       (res_text)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a block and wait, with a bound, for the edge that accepts it.
  task automatic offer(input logic [127:0] text, input logic [127:0] key, input logic mode,
                       output bit acc, output int waited);
    logic rdy_before;
    blk_text   = text;
    blk_key    = key;
    blk_encdec = mode;
    blk_valid  = 1'b1;
    acc        = 1'b0;
    waited     = 0;
    while (!acc && waited < 200) begin
      rdy_before = blk_ready;
      tick();
      waited++;
      acc = rdy_before;
    end
    check("accept_timeout", 128'(acc), 128'(1));
  endtask

  // Run one full transaction against the timeline model.
  task automatic do_block(input logic [127:0] text, input logic [127:0] key, input logic mode,
                          input int bp, input bit churn, input bit keep_valid,
                          input bit fips, input bit expect_now);
    bit           acc;
    int           waited;
    logic [127:0] exp_res;
    logic [31:0]  v;
    logic [31:0]  fw [4];
    logic [31:0]  exp_din;
    logic [127:0] tmp;
    fw[0] = FIPS_CT[127:96];
    fw[1] = FIPS_CT[95:64];
    fw[2] = FIPS_CT[63:32];
    fw[3] = FIPS_CT[31:0];
    exp_res = '0;
    offer(text, key, mode, acc, waited);
    if (!acc) return;
    if (expect_now) check("b2b_accept_cycles", 128'(waited), 128'(1));
    if (!keep_valid) blk_valid = 1'b0;
    for (int k = 0; k <= LAT + bp; k++) begin
      tmp     = text;
      exp_din = (k >= 3 && k < 7) ? tmp[127 - 32*(k-3) -: 32] : 32'h0;
      check("core_start", 128'(core_start), 128'(k < 3));
      check("core_data_in", 128'(core_data_in), 128'(exp_din));
      check("core_key_in", core_key_in, key);
      check("core_selEncDec", 128'(core_selEncDec), 128'(mode));
      check("blk_ready_busy", 128'(blk_ready), 128'(0));
      check("res_valid", 128'(res_valid), 128'(k >= LAT));
      if (k >= LAT) check("res_text", res_text, exp_res);
      if (fips && k == LAT) check("fips_vector", res_text, FIPS_CT);
      // Stand-in core: new word each cycle, seen by the DUT on the next edge.
      if (fips && k >= 68 && k <= 71) v = fw[k-68];
      else v = $urandom;
      core_data_out = v;
      if (k >= 68 && k <= 71) exp_res[127 - 32*(k-68) -: 32] = v;
      if (churn) begin
        blk_key    = rand128();
        blk_text   = rand128();
        blk_encdec = 1'($urandom_range(0, 1));
      end
      res_ready = (k < LAT) ? 1'($urandom_range(0, 1)) : (k == LAT + bp);
      tick();
    end
    res_ready = 1'b0;
    check("res_valid_after_consume", 128'(res_valid), 128'(0));
    check("blk_ready_after_consume", 128'(blk_ready), 128'(1));
  endtask

  // Accept a block, then pull reset low during WAIT and confirm the abort.
  task automatic do_abort(input logic [127:0] text, input logic [127:0] key, input logic mode);
    bit acc;
    int waited;
    int seen_valid;
    offer(text, key, mode, acc, waited);
    blk_valid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      core_data_out = $urandom;
      tick();
    end
    reset = 1'b0;
    #1;
    check("abort_core_start", 128'(core_start), 128'(0));
    check("abort_core_data_in", 128'(core_data_in), 128'(0));
    check("abort_core_key_in", core_key_in, 128'(0));
    check("abort_selEncDec", 128'(core_selEncDec), 128'(0));
    check("abort_res_valid", 128'(res_valid), 128'(0));
    check("abort_res_text", res_text, 128'(0));
    check("abort_blk_ready", 128'(blk_ready), 128'(0));
    tick();
    tick();
    check("abort_blk_ready_held", 128'(blk_ready), 128'(0));
    reset = 1'b1;
    tick();
    check("abort_blk_ready_release", 128'(blk_ready), 128'(1));
    seen_valid = 0;
    for (int k = 0; k < 90; k++) begin
      core_data_out = $urandom;
      res_ready     = 1'($urandom_range(0, 1));
      if (res_valid) seen_valid++;
      tick();
    end
    res_ready = 1'b0;
    check("abort_no_res_valid", 128'(seen_valid), 128'(0));
  endtask

  initial begin
    reset         = 1'b1;
    blk_valid     = 1'b0;
    blk_text      = '0;
    blk_key       = '0;
    blk_encdec    = 1'b0;
    core_data_out = '0;
    res_ready     = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("rst_core_start", 128'(core_start), 128'(0));
    check("rst_core_data_in", 128'(core_data_in), 128'(0));
    check("rst_core_key_in", core_key_in, 128'(0));
    check("rst_selEncDec", 128'(core_selEncDec), 128'(0));
    check("rst_res_valid", 128'(res_valid), 128'(0));
    check("rst_res_text", res_text, 128'(0));
    check("rst_blk_ready", 128'(blk_ready), 128'(0));
    tick();
    tick();
    check("rst_blk_ready_held", 128'(blk_ready), 128'(0));
    reset = 1'b1;
    tick();
    check("blk_ready_after_release", 128'(blk_ready), 128'(1));

    // Known-answer vector with exact start/load timing.
    do_block(FIPS_PT, FIPS_KEY, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    // Backpressure with blk_valid held and inputs churning.
    do_block(rand128(), rand128(), 1'b1, 20, 1'b1, 1'b1, 1'b0, 1'b0);
    // Back-to-back acceptance straight after HOLD exits.
    do_block(rand128(), rand128(), 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    do_block(rand128(), rand128(), 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b1);
    // Abort during WAIT, then a normal block completes.
    do_abort(rand128(), rand128(), 1'b1);
    do_block(FIPS_PT, FIPS_KEY, 1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b0);
    // Randomised tail.
    for (int i = 0; i < 4; i++) begin
      do_block(rand128(), rand128(), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
